uart_core_param: RTL and testbench

//  Parametrised full-duplex UART core: TX serialiser, RX deserialiser with RX FIFO, line-error flags.

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_core_param_if.sv | 26 ++
 rtl/uart_rx_fifo.sv | 43 ++++
 rtl/uart_core_param.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_core_param.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// UART core shared types: TX/RX FSM state enums and frame-geometry helpers.
// Parity states exist only when UART_PARITY_EN is defined.
package uart_pkg;

`ifdef UART_PARITY_EN
  localparam int PAR_BITS = 1;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  localparam tx_state_t TX_AFTER_DATA = TX_PARITY;
  localparam rx_state_t RX_AFTER_DATA = RX_PARITY;
`else
  localparam int PAR_BITS = 0;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  localparam tx_state_t TX_AFTER_DATA = TX_STOP;
  localparam rx_state_t RX_AFTER_DATA = RX_STOP;
`endif

  // Start + data + optional parity + stop bits.
  function automatic int frame_bits(int dw, int sb);
    return 1 + dw + PAR_BITS + sb;
  endfunction

  function automatic int half_bit(int cpb);
    return cpb / 2;
  endfunction

endpackage

// File: rtl/uart_core_param_if.sv
// Host-side byte handshake of the UART core.
// master: drives data_in/wr_en/rdy_clr/err_clr; slave: the core.
interface uart_core_param_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] data_in;
  logic              wr_en;
  logic              busy;
  logic              rdy;
  logic [DATA_W-1:0] dout;
  logic              rdy_clr;
  logic              err_clr;
  logic              frame_err;
  logic              parity_err;
  logic              overrun;

  modport master (
    output data_in, wr_en, rdy_clr, err_clr,
    input  busy, rdy, dout, frame_err, parity_err, overrun
  );

  modport slave (
    input  data_in, wr_en, rdy_clr, err_clr,
    output busy, rdy, dout, frame_err, parity_err, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous RX FIFO. Ports: clk, rst, push/din, pop, full, empty, head.
// A push while full is dropped unless a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | pop);
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: TX serialiser, RX deserialiser + FIFO, sticky errors.
// Ports: clk, rst, host (slave handshake), tx, rx, loop_en. Option macro: UART_PARITY_EN.
module uart_core_param
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic               clk,
  input  logic               rst,
  uart_core_param_if.slave   host,
  output logic               tx,
  input  logic               rx,
  input  logic               loop_en
);
  localparam int FRAME_BITS = frame_bits(DATA_W, STOP_BITS);
  localparam int HALF_BIT   = half_bit(CLKS_PER_BIT);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FRAME_BITS);
  localparam int IW = $clog2(DATA_W + 1);

  // ---------------- TX ----------------
  tx_state_t             tx_state, tx_state_n;
  logic [CW-1:0]         tx_cnt, tx_cnt_n;
  logic [PW-1:0]         tx_pos, tx_pos_n;
  logic [FRAME_BITS-1:0] tx_sh, tx_sh_n;
  logic [FRAME_BITS-1:0] tx_frame;
  logic                  tx_bit_end;

`ifdef UART_PARITY_EN
  assign tx_frame = {{STOP_BITS{1'b1}},
                     ^host.data_in ^ (PARITY_ODD != 0),
                     host.data_in, 1'b0};
`else
  assign tx_frame = {{STOP_BITS{1'b1}}, host.data_in, 1'b0};
`endif

  // The whole frame is shifted out LSB first; ones refill from the top
  // so the line rests high once the frame is gone.
  assign tx         = tx_sh[0];
  assign host.busy  = (tx_state != TX_IDLE);
  assign tx_bit_end = (tx_cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_pos   <= '0;
      tx_sh    <= '1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_pos   <= tx_pos_n;
      tx_sh    <= tx_sh_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_pos_n   = tx_pos;
    tx_sh_n    = tx_sh;
    if (tx_state != TX_IDLE) begin
      tx_cnt_n = tx_bit_end ? '0 : tx_cnt + CW'(1);
      if (tx_bit_end) begin
        tx_sh_n  = {1'b1, tx_sh[FRAME_BITS-1:1]};
        tx_pos_n = tx_pos + PW'(1);
      end
    end
    unique case (tx_state)
      TX_IDLE: begin
        if (host.wr_en) begin
          tx_state_n = TX_START;
          tx_cnt_n   = '0;
          tx_pos_n   = '0;
          tx_sh_n    = tx_frame;
        end
      end
      TX_START: if (tx_bit_end) tx_state_n = TX_DATA;
      TX_DATA: begin
        if (tx_bit_end && tx_pos == PW'(DATA_W))
          tx_state_n = TX_AFTER_DATA;
      end
`ifdef UART_PARITY_EN
      TX_PARITY: if (tx_bit_end) tx_state_n = TX_STOP;
`endif
      TX_STOP: begin
        if (tx_bit_end && tx_pos == PW'(FRAME_BITS - 1)) begin
          tx_state_n = TX_IDLE;
          tx_pos_n   = '0;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // ---------------- RX ----------------
  rx_state_t         rx_state, rx_state_n;
  logic [CW-1:0]     rx_cnt, rx_cnt_n;
  logic [IW-1:0]     rx_idx, rx_idx_n;
  logic [DATA_W-1:0] rx_sh, rx_sh_n;
  logic              sync1, rx_in, rx_prev;
  logic              rx_half, rx_full;
  logic              parity_bad;
  logic              rx_push, set_fe, set_pe, set_ov;
  logic              fifo_full, fifo_empty;
  logic              fe, pe, ov;

`ifdef UART_PARITY_EN
  logic rx_par, rx_par_n;
  assign parity_bad = ((^rx_sh) ^ rx_par) != (PARITY_ODD != 0);
`else
  // Parity sense has no meaning without a parity bit.
  logic unused_par;
  assign unused_par = (PARITY_ODD != 0);
  assign parity_bad = 1'b0;
`endif

  assign rx_half = (rx_cnt == CW'(HALF_BIT - 1));
  assign rx_full = (rx_cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b1;
      rx_in    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_sh    <= '0;
`ifdef UART_PARITY_EN
      rx_par   <= 1'b0;
`endif
      fe       <= 1'b0;
      pe       <= 1'b0;
      ov       <= 1'b0;
    end else begin
      sync1    <= loop_en ? tx : rx;
      rx_in    <= sync1;
      rx_prev  <= rx_in;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_sh    <= rx_sh_n;
`ifdef UART_PARITY_EN
      rx_par   <= rx_par_n;
`endif
      fe       <= set_fe | (fe & ~host.err_clr);
      pe       <= set_pe | (pe & ~host.err_clr);
      ov       <= set_ov | (ov & ~host.err_clr);
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_idx_n   = rx_idx;
    rx_sh_n    = rx_sh;
`ifdef UART_PARITY_EN
    rx_par_n   = rx_par;
`endif
    rx_push    = 1'b0;
    set_fe     = 1'b0;
    set_pe     = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev && !rx_in) rx_state_n = RX_START;
      end
      RX_START: begin
        if (rx_half) begin
          rx_cnt_n   = '0;
          rx_idx_n   = '0;
          rx_state_n = rx_in ? RX_IDLE : RX_DATA;
        end else rx_cnt_n = rx_cnt + CW'(1);
      end
      RX_DATA: begin
        if (rx_full) begin
          rx_cnt_n = '0;
          rx_sh_n  = {rx_in, rx_sh[DATA_W-1:1]};
          rx_idx_n = rx_idx + IW'(1);
          if (rx_idx == IW'(DATA_W - 1)) rx_state_n = RX_AFTER_DATA;
        end else rx_cnt_n = rx_cnt + CW'(1);
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_full) begin
          rx_cnt_n   = '0;
          rx_par_n   = rx_in;
          rx_state_n = RX_STOP;
        end else rx_cnt_n = rx_cnt + CW'(1);
      end
`endif
      RX_STOP: begin
        if (rx_full) begin
          rx_cnt_n = '0;
          if (!rx_in) begin
            set_fe     = 1'b1;
            rx_state_n = RX_WAIT_HIGH;
          end else if (parity_bad) begin
            set_pe     = 1'b1;
            rx_state_n = RX_IDLE;
          end else begin
            rx_push    = 1'b1;
            rx_state_n = RX_IDLE;
          end
        end else rx_cnt_n = rx_cnt + CW'(1);
      end
      // A held-low line (break) must not look like a fresh start bit.
      RX_WAIT_HIGH: if (rx_in) rx_state_n = RX_IDLE;
      default: rx_state_n = RX_IDLE;
    endcase
  end

  assign set_ov = rx_push & fifo_full & ~host.rdy_clr;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .din   (rx_sh),
    .pop   (host.rdy_clr),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (host.dout)
  );

  assign host.rdy        = ~fifo_empty;
  assign host.frame_err  = fe;
  assign host.parity_err = pe;
  assign host.overrun    = ov;
endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param (CLKS_PER_BIT=16, 8 data bits, 1 stop, depth 4).
// Expected RX bytes live in a scoreboard queue filled when writes are accepted.
module tb_uart_core_param;
  localparam int CPB = 16;
`ifdef UART_PARITY_EN
  localparam int  BUSY_CYC = 176;
  localparam bit  PAR_EN   = 1'b1;
`else
  localparam int  BUSY_CYC = 160;
  localparam bit  PAR_EN   = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic loop_en = 1'b1;
  logic tx;

  uart_core_param_if #(.DATA_W(8)) host ();

  uart_core_param #(
    .DATA_W       (8),
    .CLKS_PER_BIT (CPB),
    .STOP_BITS    (1),
    .FIFO_DEPTH   (4),
    .PARITY_ODD   (0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .host    (host),
    .tx      (tx),
    .rx      (rx),
    .loop_en (loop_en)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic exp_ovr = 1'b0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: a write is taken only when idle; 4-entry FIFO, extra frame -> overrun.
  task automatic send(input logic [7:0] d);
    logic acc;
    acc = !host.busy;
    host.data_in = d;
    host.wr_en   = 1'b1;
    tick(1);
    host.wr_en   = 1'b0;
    if (acc) begin
      if (sb.size() < 4) sb.push_back(d);
      else exp_ovr = 1'b1;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (host.busy && n < 400) begin
      tick(1);
      n++;
    end
    chk({tag, "_idle_timeout"}, host.busy, 1'b0);
  endtask

  task automatic wait_rdy(input string tag);
    int n = 0;
    while (!host.rdy && n < 400) begin
      tick(1);
      n++;
    end
    chk({tag, "_rdy_timeout"}, host.rdy, 1'b1);
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] e;
    e = (sb.size() > 0) ? sb.pop_front() : 8'h00;
    chk({tag, "_rdy"}, host.rdy, 1'b1);
    chk({tag, "_dout"}, host.dout, e);
    host.rdy_clr = 1'b1;
    tick(1);
    host.rdy_clr = 1'b0;
  endtask

  task automatic pulse_err_clr();
    host.err_clr = 1'b1;
    tick(1);
    host.err_clr = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic par,
                          input logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
    if (PAR_EN) begin
      rx = par;
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
    if (!stop) tick(3 * CPB);
    rx = 1'b1;
    tick(2 * CPB);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] t2 [4];
    logic [7:0] t3 [5];
    host.data_in = '0;
    host.wr_en   = 1'b0;
    host.rdy_clr = 1'b0;
    host.err_clr = 1'b0;
    tick(3);

    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", host.busy, 1'b0);
    chk("rst_rdy", host.rdy, 1'b0);
    chk("rst_dout", host.dout, 8'h00);
    chk("rst_fe", host.frame_err, 1'b0);
    chk("rst_pe", host.parity_err, 1'b0);
    chk("rst_ovr", host.overrun, 1'b0);
    rst = 1'b0;
    tick(2);

    // 1: single loopback byte, busy length, pop, pop-when-empty
    send(8'h41);
    n = 0;
    while (host.busy && n < 1000) begin
      n++;
      tick(1);
    end
    chk("t1_busy_cycles", n, BUSY_CYC);
    wait_rdy("t1");
    pop_chk("t1");
    chk("t1_rdy_clr", host.rdy, 1'b0);
    host.rdy_clr = 1'b1;
    tick(1);
    host.rdy_clr = 1'b0;
    chk("t1_empty_pop_rdy", host.rdy, 1'b0);
    chk("t1_empty_pop_dout", host.dout, 8'h00);

    // 2: four bytes queued in order; a write during busy is ignored
    t2 = '{8'h55, 8'hA5, 8'h00, 8'hFF};
    for (int i = 0; i < 4; i++) begin
      send(t2[i]);
      if (i == 0) send(8'hEE);
      wait_idle("t2");
      tick(CPB);
    end
    for (int i = 0; i < 4; i++) pop_chk("t2");
    chk("t2_drained", host.rdy, 1'b0);
    chk("t2_fe", host.frame_err, 1'b0);
    chk("t2_ovr", host.overrun, 1'b0);

    // 3: five bytes into a 4-deep FIFO
    t3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66};
    for (int i = 0; i < 5; i++) begin
      send(t3[i]);
      wait_idle("t3");
      tick(CPB);
    end
    chk("t3_ovr", host.overrun, exp_ovr);
    for (int i = 0; i < 4; i++) pop_chk("t3");
    chk("t3_drained", host.rdy, 1'b0);
    chk("t3_ovr_sticky", host.overrun, 1'b1);
    pulse_err_clr();
    chk("t3_ovr_clr", host.overrun, 1'b0);

    // 4: external rx, bad stop bit then a good frame
    loop_en = 1'b0;
    rx_frame(8'h3C, ^8'h3C, 1'b0);
    chk("t4_fe", host.frame_err, 1'b1);
    chk("t4_rdy", host.rdy, 1'b0);
    rx_frame(8'h5A, ^8'h5A, 1'b1);
    sb.push_back(8'h5A);
    wait_rdy("t4");
    pop_chk("t4_good");
    chk("t4_fe_sticky", host.frame_err, 1'b1);
    pulse_err_clr();
    chk("t4_fe_clr", host.frame_err, 1'b0);

    // 5: short glitch, then reset in the middle of a TX frame
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(3 * CPB);
    chk("t5_glitch_rdy", host.rdy, 1'b0);
    chk("t5_glitch_fe", host.frame_err, 1'b0);
    chk("t5_glitch_pe", host.parity_err, 1'b0);
    chk("t5_glitch_ovr", host.overrun, 1'b0);
    loop_en = 1'b1;
    send(8'hC3);
    tick(50);
    chk("t5_tx_bit2", tx, 1'b0);
    rst = 1'b1;
    #1;
    chk("t5_rst_tx", tx, 1'b1);
    chk("t5_rst_busy", host.busy, 1'b0);
    rst = 1'b0;
    sb.delete();
    tick(2 * CPB);
    chk("t5_rst_rdy", host.rdy, 1'b0);
    send(8'h7E);
    wait_idle("t5");
    wait_rdy("t5");
    pop_chk("t5_after_rst");

`ifdef UART_PARITY_EN
    // 6: 8'h03 with wrong (odd) parity bit under even parity
    loop_en = 1'b0;
    rx_frame(8'h03, 1'b1, 1'b1);
    chk("t6_pe", host.parity_err, 1'b1);
    chk("t6_rdy", host.rdy, 1'b0);
    pulse_err_clr();
    chk("t6_pe_clr", host.parity_err, 1'b0);
`else
    chk("t6_pe_tied", host.parity_err, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
